// File: rtl/fp_mult_pkg.sv
// Shared types and constants for the FP32 multiplier: rounding modes,
// operand classes, status bit positions and special encodings.
package fp_mult_pkg;

    localparam int unsigned BIAS = 127;

    localparam logic [30:0] QNAN       = 31'h7FC00000;
    localparam logic [30:0] INF_MAG    = 31'h7F800000;
    localparam logic [30:0] MAX_NORMAL = 31'h7F7FFFFF;
    localparam logic [30:0] MIN_NORMAL = 31'h00800000;

    localparam int unsigned ST_ZERO    = 0;
    localparam int unsigned ST_INF     = 1;
    localparam int unsigned ST_NAN     = 2;
    localparam int unsigned ST_TINY    = 3;
    localparam int unsigned ST_HUGE    = 4;
    localparam int unsigned ST_INEXACT = 5;

    typedef enum logic [2:0] {
        RND_NE = 3'd0,
        RND_TZ = 3'd1,
        RND_UP = 3'd2,
        RND_DN = 3'd3,
        RND_NA = 3'd4,
        RND_AW = 3'd5
    } rnd_mode_e;

    typedef enum logic [1:0] {
        CLS_ZERO = 2'd0,
        CLS_NORM = 2'd1,
        CLS_INF  = 2'd2
    } fp_class_e;

    function automatic fp_class_e classify(input logic [7:0] exp);
        if (exp == 8'h00)      return CLS_ZERO;
        else if (exp == 8'hFF) return CLS_INF;
        else                   return CLS_NORM;
    endfunction

    // True when the mode pushes the magnitude away from zero for this sign.
    function automatic logic rounds_away(input rnd_mode_e mode, input logic sign);
        return (mode == RND_AW) || (mode == RND_UP && !sign) || (mode == RND_DN && sign);
    endfunction

endpackage

// File: rtl/fp_round.sv
// Rounds a 24-bit mantissa using guard/sticky and the selected mode;
// reports carry-out of the mantissa and whether the result is inexact.
module fp_round
    import fp_mult_pkg::*;
(
    input  logic [23:0] mant,
    input  logic        guard,
    input  logic        sticky,
    input  logic        sign,
    input  rnd_mode_e   mode,
    output logic [23:0] mant_r,
    output logic        carry,
    output logic        inexact
);

    logic        inc;
    logic [24:0] sum;

    always_comb begin
        inexact = guard | sticky;
        inc     = 1'b0;
        unique case (mode)
            RND_NE:  inc = guard & (sticky | mant[0]);
            RND_TZ:  inc = 1'b0;
            RND_UP:  inc = ~sign & inexact;
            RND_DN:  inc = sign & inexact;
            RND_NA:  inc = guard;
            RND_AW:  inc = inexact;
            default: inc = guard & (sticky | mant[0]);
        endcase
        sum    = {1'b0, mant} + {24'h0, inc};
        carry  = sum[24];
        mant_r = sum[23:0];
    end

endmodule

// File: rtl/fp_mult_zero_inf.sv
// FP32 multiplier with one register stage, denormal flush-to-zero,
// zero/inf/NaN special cases and an aligned 8-bit status word.
module fp_mult_zero_inf
    import fp_mult_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [2:0]  rnd,
    output logic [31:0] z,
    output logic [7:0]  status
);

    logic        sign;
    fp_class_e   cls_a, cls_b;
    rnd_mode_e   mode;

    logic [47:0]        prod;
    logic signed [9:0]  e_raw, e_norm, e_post;
    logic [23:0]        mant, mant_r;
    logic               guard, sticky, carry, inexact;
    logic [22:0]        frac;

    logic [31:0] z_next;
    logic [7:0]  status_next;

    assign sign  = a[31] ^ b[31];
    assign cls_a = classify(a[30:23]);
    assign cls_b = classify(b[30:23]);
    assign mode  = (rnd > 3'd5) ? RND_NE : rnd_mode_e'(rnd);

    assign prod  = {24'h0, 1'b1, a[22:0]} * {24'h0, 1'b1, b[22:0]};
    assign e_raw = 10'({2'b00, a[30:23]}) + 10'({2'b00, b[30:23]}) - 10'(BIAS);

    always_comb begin
        if (prod[47]) begin
            mant   = prod[47:24];
            guard  = prod[23];
            sticky = |prod[22:0];
        end else begin
            mant   = prod[46:23];
            guard  = prod[22];
            sticky = |prod[21:0];
        end
        e_norm = e_raw + {9'h0, prod[47]};
    end

    fp_round u_round (
        .mant    (mant),
        .guard   (guard),
        .sticky  (sticky),
        .sign    (sign),
        .mode    (mode),
        .mant_r  (mant_r),
        .carry   (carry),
        .inexact (inexact)
    );

    // A carry leaves mantissa 1.000..0, so only the exponent moves.
    assign frac   = carry ? 23'h0 : mant_r[22:0];
    assign e_post = e_norm + {9'h0, carry};

    always_comb begin
        z_next      = '0;
        status_next = '0;
        if ((cls_a == CLS_ZERO && cls_b == CLS_INF) || (cls_a == CLS_INF && cls_b == CLS_ZERO)) begin
            z_next              = {sign, QNAN};
            status_next[ST_NAN] = 1'b1;
        end else if (cls_a == CLS_INF || cls_b == CLS_INF) begin
            z_next              = {sign, INF_MAG};
            status_next[ST_INF] = 1'b1;
        end else if (cls_a == CLS_ZERO || cls_b == CLS_ZERO) begin
            z_next               = {sign, 31'h0};
            status_next[ST_ZERO] = 1'b1;
        end else if (e_post >= 10'sd255) begin
            status_next[ST_HUGE]    = 1'b1;
            status_next[ST_INEXACT] = 1'b1;
            if (mode == RND_NE || mode == RND_NA || rounds_away(mode, sign)) begin
                z_next              = {sign, INF_MAG};
                status_next[ST_INF] = 1'b1;
            end else begin
                z_next = {sign, MAX_NORMAL};
            end
        end else if (e_post <= 10'sd0) begin
            status_next[ST_TINY]    = 1'b1;
            status_next[ST_INEXACT] = 1'b1;
            if (rounds_away(mode, sign)) begin
                z_next = {sign, MIN_NORMAL};
            end else begin
                z_next               = {sign, 31'h0};
                status_next[ST_ZERO] = 1'b1;
            end
        end else begin
            z_next                  = {sign, e_post[7:0], frac};
            status_next[ST_INEXACT] = inexact;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            z      <= '0;
            status <= '0;
        end else begin
            z      <= z_next;
            status <= status_next;
        end
    end

endmodule

// File: tb/tb_fp_mult_zero_inf.sv
// Directed and randomized checks of fp_mult_zero_inf against an
// arithmetic reference model built on exact integer products.
module tb_fp_mult_zero_inf;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] a, b;
    logic [2:0]  rnd;
    logic [31:0] z;
    logic [7:0]  status;

    int n_checks = 0;
    int n_fail   = 0;

    fp_mult_zero_inf dut (
        .clk    (clk),
        .rst    (rst),
        .a      (a),
        .b      (b),
        .rnd    (rnd),
        .z      (z),
        .status (status)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Reference: exact product, quotient/remainder rounding against one half-ulp.
    function automatic void ref_mult(input logic [31:0] ia, input logic [31:0] ib,
                                     input logic [2:0] irnd,
                                     output logic [31:0] oz, output logic [7:0] ost);
        int unsigned ea, eb, m, sh;
        int e;
        logic s;
        longint unsigned p, q, rem, half, inc;
        bit away, inf_out;
        ea = ia[30:23];
        eb = ib[30:23];
        s  = ia[31] ^ ib[31];
        m  = (irnd > 5) ? 0 : irnd;
        ost = 8'h00;
        away = (m == 5) || (m == 2 && !s) || (m == 3 && s);
        if ((ea == 0 && eb == 255) || (ea == 255 && eb == 0)) begin
            oz = {s, 31'h7FC00000}; ost = 8'h04;
        end else if (ea == 255 || eb == 255) begin
            oz = {s, 31'h7F800000}; ost = 8'h02;
        end else if (ea == 0 || eb == 0) begin
            oz = {s, 31'h0}; ost = 8'h01;
        end else begin
            p = (longint'(ia[22:0]) + 64'd8388608) * (longint'(ib[22:0]) + 64'd8388608);
            e = int'(ea) + int'(eb) - 127;
            if (p >= (64'd1 << 47)) begin sh = 24; e++; end
            else sh = 23;
            q    = p >> sh;
            rem  = p - (q << sh);
            half = 64'd1 << (sh - 1);
            case (m)
                0: inc = (rem > half || (rem == half && q[0])) ? 1 : 0;
                1: inc = 0;
                2: inc = (!s && rem != 0) ? 1 : 0;
                3: inc = (s && rem != 0) ? 1 : 0;
                4: inc = (rem >= half) ? 1 : 0;
                default: inc = (rem != 0) ? 1 : 0;
            endcase
            q += inc;
            if (q == (64'd1 << 24)) begin q = q >> 1; e++; end
            if (e >= 255) begin
                inf_out = (m == 0) || (m == 4) || away;
                oz  = inf_out ? {s, 31'h7F800000} : {s, 31'h7F7FFFFF};
                ost = inf_out ? 8'h32 : 8'h30;
            end else if (e <= 0) begin
                oz  = away ? {s, 31'h00800000} : {s, 31'h0};
                ost = away ? 8'h28 : 8'h29;
            end else begin
                oz  = {s, 8'(e), q[22:0]};
                ost = (rem != 0) ? 8'h20 : 8'h00;
            end
        end
    endfunction

    task automatic apply(input logic [31:0] ia, input logic [31:0] ib, input logic [2:0] irnd,
                         input logic irst);
        @(negedge clk);
        a = ia; b = ib; rnd = irnd; rst = irst;
        @(posedge clk);
        #1;
    endtask

    task automatic directed(input string tag, input logic [31:0] ia, input logic [31:0] ib,
                            input logic [2:0] irnd, input logic [31:0] ez, input logic [7:0] est);
        apply(ia, ib, irnd, 1'b0);
        check({tag, "_z"}, z, ez);
        check({tag, "_st"}, {24'h0, status}, {24'h0, est});
    endtask

    function automatic logic [7:0] rand_exp();
        case ($urandom_range(0, 9))
            0:       return 8'h00;
            1:       return 8'hFF;
            2:       return 8'($urandom_range(190, 254));
            3:       return 8'($urandom_range(1, 70));
            default: return 8'($urandom_range(1, 254));
        endcase
    endfunction

    initial begin
        logic [31:0] ra, rb, ez;
        logic [7:0]  est;
        logic [2:0]  rr;

        a = '0; b = '0; rnd = '0; rst = 1'b1;

        apply(32'h3F800000, 32'h40000000, 3'd0, 1'b1);
        check("reset_z", z, 32'h0);
        check("reset_st", {24'h0, status}, 32'h0);
        apply(32'h3F800000, 32'h40000000, 3'd0, 1'b0);
        check("post_reset_z", z, 32'h40000000);
        check("post_reset_st", {24'h0, status}, 32'h0);

        directed("one_x_two",  32'h3F800000, 32'h40000000, 3'd0, 32'h40000000, 8'h00);
        directed("neg_zero",   32'h80000000, 32'h3F800000, 3'd0, 32'h80000000, 8'h01);
        directed("zero_inf",   32'h00000000, 32'h7F800000, 3'd0, 32'h7FC00000, 8'h04);
        directed("inf_zero",   32'h7F800000, 32'h00000000, 3'd0, 32'h7FC00000, 8'h04);
        directed("inf_one",    32'h7F800000, 32'h3F800000, 3'd0, 32'h7F800000, 8'h02);
        directed("ovf_ne",     32'h7F000000, 32'h40000000, 3'd0, 32'h7F800000, 8'h32);
        directed("ovf_tz",     32'h7F000000, 32'h40000000, 3'd1, 32'h7F7FFFFF, 8'h30);
        directed("unf_ne",     32'h00800000, 32'h3F000000, 3'd0, 32'h00000000, 8'h29);
        directed("unf_up",     32'h00800000, 32'h3F000000, 3'd2, 32'h00800000, 8'h28);
        directed("nan_in_inf", 32'h7FC00001, 32'hBF800000, 3'd0, 32'hFF800000, 8'h02);
        directed("denorm_in",  32'h00000123, 32'hC0000000, 3'd0, 32'h80000000, 8'h01);
        directed("ovf_rnd7",   32'h7F000000, 32'h40000000, 3'd7, 32'h7F800000, 8'h32);
        directed("unf_dn_neg", 32'h80800000, 32'h3F000000, 3'd3, 32'h80800000, 8'h28);

        apply(32'h3FC00000, 32'h3FC00000, 3'd0, 1'b0);
        apply(32'h3FC00000, 32'h3FC00000, 3'd0, 1'b1);
        check("mid_reset_z", z, 32'h0);
        check("mid_reset_st", {24'h0, status}, 32'h0);

        for (int i = 0; i < 600; i++) begin
            ra = {1'($urandom), rand_exp(), 23'($urandom)};
            rb = {1'($urandom), rand_exp(), 23'($urandom)};
            if ($urandom_range(0, 7) == 0) ra[22:0] = 23'h0;
            if ($urandom_range(0, 7) == 0) rb[22:0] = 23'h7FFFFF;
            rr = 3'($urandom_range(0, 7));
            ref_mult(ra, rb, rr, ez, est);
            apply(ra, rb, rr, 1'b0);
            check("rand_z", z, ez);
            check("rand_st", {24'h0, status}, {24'h0, est});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
